// File: rtl/game_pkg.sv
// Shared definitions for the button front end and game control:
// direction encodings, command word layout, button bit order and the
// states used to track a single press.
package game_pkg;

  // Direction encodings carried in the low bits of every command.
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Command word layout: {long, dir[1:0]}.
  localparam int EVT_W    = 3;
  localparam int LONG_BIT = 2;
  localparam int DIR_MSB  = 1;
  localparam int DIR_LSB  = 0;

  // Bit positions of the four buttons inside the synchronised vector.
  localparam int BTN_N = 0;
  localparam int BTN_E = 1;
  localparam int BTN_S = 2;
  localparam int BTN_W = 3;

  // Press tracking: no press, press being timed, press already reported long.
  typedef enum logic [1:0] {
    IDLE,
    HELD,
    HELD_LONG
  } pressState_e;

  // Picks one direction when several buttons are down; north beats east
  // beats south beats west. Only meaningful when at least one bit is set.
  function automatic logic [1:0] prioDir(input logic [3:0] btn);
    logic [1:0] dir;
    if (btn[BTN_N]) begin
      dir = DIR_N;
    end else if (btn[BTN_E]) begin
      dir = DIR_E;
    end else if (btn[BTN_S]) begin
      dir = DIR_S;
    end else begin
      dir = DIR_W;
    end
    return dir;
  endfunction

  // Packs a long flag and a direction into a command word.
  function automatic logic [EVT_W-1:0] makeCmd(input logic isLong, input logic [1:0] dir);
    logic [EVT_W-1:0] cmd;
    cmd                  = '0;
    cmd[LONG_BIT]        = isLong;
    cmd[DIR_MSB:DIR_LSB] = dir;
    return cmd;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Small circular command queue. Writes come from the press decoder as
// single-cycle pushes; reads are a valid/ready handshake on the head entry.
// When full, a push is still accepted if the head leaves in the same cycle,
// otherwise it is dropped and reported on drop_o for that cycle.
module event_fifo
  import game_pkg::*;
#(
  parameter int WIDTH = EVT_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  output logic             drop_o,
  output logic             rdValid_o,
  output logic [WIDTH-1:0] rdData_o,
  input  logic             rdReady_i
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wrPtr_q;
  logic [PTR_W-1:0]    wrPtr_d;
  logic [PTR_W-1:0]    rdPtr_q;
  logic [PTR_W-1:0]    rdPtr_d;
  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] count_d;

  logic isFull;
  logic popFire;
  logic pushFire;

  assign rdValid_o = (count_q != '0);
  assign isFull    = (count_q == CNT_BITS'(DEPTH));
  assign popFire   = rdValid_o & rdReady_i;
  assign pushFire  = push_i & (~isFull | popFire);
  assign drop_o    = push_i & isFull & ~popFire;

  // Head is only presented while something is queued; zero otherwise.
  assign rdData_o  = rdValid_o ? mem_q[rdPtr_q] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushFire) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (popFire) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({pushFire, popFire})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous reset to an empty queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (pushFire) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Turns debounced press/release toggles plus the raw direction buttons into
// queued game commands {long, dir}. The toggle only says "something changed";
// whether it was a press or a release is decided from the live button state,
// so a missed edge or a reset in the middle of a press can never leave the
// decoder permanently inverted.
module button_event_decoder
  import game_pkg::*;
#(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int CNT_W       = 26,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_toggle,
  input  logic             btn_north,
  input  logic             btn_east,
  input  logic             btn_south,
  input  logic             btn_west,
  output logic             cmd_valid,
  output logic [EVT_W-1:0] cmd_code,
  input  logic             cmd_ready,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [3:0]       rawBtn;
  logic [3:0]       btnSync1_q;
  logic [3:0]       btnSync2_q;
  logic             toggle_q;
  logic             toggleEdge;
  logic             pressedNext;

  pressState_e      state_q;
  pressState_e      state_d;
  logic [CNT_W-1:0] holdCnt_q;
  logic [CNT_W-1:0] holdCnt_d;
  logic [1:0]       dir_q;
  logic [1:0]       dir_d;

  logic             evtPush;
  logic [EVT_W-1:0] evtCode;
  logic             fifoDrop;
  logic             overflow_q;

  assign rawBtn[BTN_N] = btn_north;
  assign rawBtn[BTN_E] = btn_east;
  assign rawBtn[BTN_S] = btn_south;
  assign rawBtn[BTN_W] = btn_west;

  // Two-stage synchroniser for the asynchronous direction buttons.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btnSync1_q <= '0;
      btnSync2_q <= '0;
    end else begin
      btnSync1_q <= rawBtn;
      btnSync2_q <= btnSync1_q;
    end
  end

  // Remember the last toggle level, including during reset, so the first
  // cycle after reset does not see a phantom edge.
  always_ff @(posedge clk) begin
    toggle_q <= btn_toggle;
  end

  assign toggleEdge  = btn_toggle ^ toggle_q;
  assign pressedNext = |btnSync2_q;

  // Press FSM: classify toggle edges by the button state and time the hold.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    dir_d     = dir_q;
    evtPush   = 1'b0;
    evtCode   = '0;
    case (state_q)
      IDLE: begin
        if (toggleEdge && pressedNext) begin
          state_d   = HELD;
          dir_d     = prioDir(btnSync2_q);
          holdCnt_d = '0;
        end
      end
      HELD: begin
        if (toggleEdge && !pressedNext) begin
          evtPush   = 1'b1;
          evtCode   = makeCmd(1'b0, dir_q);
          state_d   = IDLE;
          holdCnt_d = '0;
        end else if (holdCnt_q == LONG_LAST) begin
          evtPush   = 1'b1;
          evtCode   = makeCmd(1'b1, dir_q);
          state_d   = HELD_LONG;
        end else begin
          holdCnt_d = holdCnt_q + CNT_W'(1);
        end
      end
      HELD_LONG: begin
        if (toggleEdge && !pressedNext) begin
          state_d   = IDLE;
          holdCnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        holdCnt_d = '0;
      end
    endcase
  end

  // Press FSM state, hold counter and latched direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      holdCnt_q <= '0;
      dir_q     <= DIR_N;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      dir_q     <= dir_d;
    end
  end

  event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (evtPush),
    .pushData_i (evtCode),
    .drop_o     (fifoDrop),
    .rdValid_o  (cmd_valid),
    .rdData_o   (cmd_code),
    .rdReady_i  (cmd_ready)
  );

  // Sticky drop indicator; only a reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (fifoDrop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;

endmodule
